// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Clears the RAM after reset, then serialises port requests onto the RAM strobes.
module ram_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              ram_write,
   output logic              ram_read,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              init_done
);

   typedef enum logic [1:0] {INIT, IDLE, ISSUE, RDWAIT} state_t;

   localparam logic [ADDR_W:0] CNT_ONE = 1;

   state_t            state;
   logic [ADDR_W:0]   init_cnt;   // extra MSB flags that every address has been cleared
   logic              last_srv;   // port served most recently
   logic              owner;      // port of the transaction in flight
   logic              cur_rd;

   logic              pick1;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // Port 1 wins when alone, or when both ask and port 0 was served last.
   assign pick1     = req1 & (~req0 | ~last_srv);
   assign sel_we    = pick1 ? we1    : we0;
   assign sel_addr  = pick1 ? addr1  : addr0;
   assign sel_wdata = pick1 ? wdata1 : wdata0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= INIT;
         init_cnt  <= '0;
         last_srv  <= 1'b1;
         owner     <= 1'b0;
         cur_rd    <= 1'b0;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
         ram_write <= 1'b0;
         ram_read  <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         busy      <= 1'b1;
         init_done <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout; the defaults below are
         // overridden later in the same block, so every pulse lasts one cycle.
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
         ram_write <= 1'b0;
         ram_read  <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;

         case (state)
            INIT: begin
               if (init_cnt[ADDR_W]) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  init_done <= 1'b1;
               end else begin
                  ram_write <= 1'b1;
                  ram_addr  <= init_cnt[ADDR_W-1:0];
                  init_cnt  <= init_cnt + CNT_ONE;
               end
            end

            IDLE: begin
               if (req0 || req1) begin
                  state    <= ISSUE;
                  busy     <= 1'b1;
                  owner    <= pick1;
                  last_srv <= pick1;
                  cur_rd   <= ~sel_we;
                  gnt0     <= ~pick1;
                  gnt1     <= pick1;
                  ram_addr <= sel_addr;
                  if (sel_we) begin
                     ram_write <= 1'b1;
                     ram_wdata <= sel_wdata;
                  end else begin
                     ram_read  <= 1'b1;
                  end
               end
            end

            ISSUE: begin
               if (cur_rd) begin
                  state <= RDWAIT;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            RDWAIT: begin
               // RAM data is valid now, one cycle after the read strobe.
               state <= IDLE;
               busy  <= 1'b0;
               if (owner) begin
                  rdata1  <= ram_rdata;
                  rvalid1 <= 1'b1;
               end else begin
                  rdata0  <= ram_rdata;
                  rvalid0 <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: external RAM model, cycle-accurate expectation model,
// per-cycle comparison plus directed scenarios with literal expectations.
module tb_ram_arbiter;

   logic       clk;
   logic       reset;
   logic       req0, req1, we0, we1;
   logic [3:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       gnt0, gnt1, rvalid0, rvalid1;
   logic [7:0] rdata0, rdata1;
   logic       ram_write, ram_read;
   logic [3:0] ram_addr;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata;
   logic       busy, init_done;

   int n_cmp = 0;
   int n_bad = 0;
   int init_writes;

   ram_arbiter dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .ram_write(ram_write), .ram_read(ram_read),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .busy(busy), .init_done(init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External synchronous RAM, preloaded with junk so the clear is observable.
   logic [7:0] ram [16];
   initial begin
      for (int i = 0; i < 16; i++) ram[i] = 8'h5C;
      ram_rdata = 8'h00;
   end
   always @(posedge clk) begin
      if (ram_write) ram[ram_addr] <= ram_wdata;
      if (ram_read)  ram_rdata <= ram[ram_addr];
   end

   // Expectation model: clear sequence, then a countdown of cycles each
   // transaction occupies, with the memory contents held as a plain array.
   typedef struct packed {
      logic [4:0]       init_idx;  // 0..15 clearing, 16 done-flag cycle, 17 running
      logic [1:0]       left;      // cycles until the next arbitration
      logic             owner;
      logic             is_rd;
      logic [3:0]       addr;
      logic             last;
      logic [15:0][7:0] mem;
      logic             e_gnt0, e_gnt1, e_rv0, e_rv1;
      logic [7:0]       e_rd0, e_rd1;
      logic             e_wr, e_rdst;
      logic [3:0]       e_addr;
      logic [7:0]       e_wdata;
      logic             e_busy, e_done;
   } model_t;

   model_t m;

   function automatic model_t model_reset(model_t c);
      model_t n;
      n = c;
      n.init_idx = 5'd0;  n.left = 2'd0;  n.owner = 1'b0;  n.is_rd = 1'b0;
      n.addr = 4'd0;      n.last = 1'b1;
      n.e_gnt0 = 1'b0;    n.e_gnt1 = 1'b0;  n.e_rv0 = 1'b0;  n.e_rv1 = 1'b0;
      n.e_rd0 = 8'd0;     n.e_rd1 = 8'd0;   n.e_wr = 1'b0;   n.e_rdst = 1'b0;
      n.e_addr = 4'd0;    n.e_wdata = 8'd0; n.e_busy = 1'b1; n.e_done = 1'b0;
      return n;
   endfunction

   function automatic model_t model_step(model_t c,
         logic r0, logic w0, logic [3:0] a0, logic [7:0] d0,
         logic r1, logic w1, logic [3:0] a1, logic [7:0] d1);
      model_t     n;
      logic       win, w;
      logic [3:0] a;
      logic [7:0] d;
      n = c;
      n.e_gnt0 = 1'b0; n.e_gnt1 = 1'b0; n.e_rv0 = 1'b0; n.e_rv1 = 1'b0;
      n.e_wr = 1'b0;   n.e_rdst = 1'b0; n.e_addr = 4'd0; n.e_wdata = 8'd0;
      if (c.init_idx < 5'd16) begin
         n.e_wr = 1'b1;
         n.e_addr = c.init_idx[3:0];
         n.mem[c.init_idx[3:0]] = 8'd0;
         n.init_idx = c.init_idx + 5'd1;
      end else if (c.init_idx == 5'd16) begin
         n.init_idx = 5'd17;
         n.e_busy = 1'b0;
         n.e_done = 1'b1;
      end else if (c.left != 2'd0) begin
         n.left = c.left - 2'd1;
         if (c.left == 2'd1) begin
            n.e_busy = 1'b0;
            if (c.is_rd && c.owner) begin
               n.e_rv1 = 1'b1;
               n.e_rd1 = c.mem[c.addr];
            end else if (c.is_rd) begin
               n.e_rv0 = 1'b1;
               n.e_rd0 = c.mem[c.addr];
            end
         end
      end else if (r0 || r1) begin
         win = (r0 && r1) ? ~c.last : r1;
         w = win ? w1 : w0;
         a = win ? a1 : a0;
         d = win ? d1 : d0;
         n.last = win;  n.owner = win;  n.addr = a;  n.is_rd = ~w;
         n.e_gnt0 = ~win;  n.e_gnt1 = win;
         n.e_addr = a;  n.e_busy = 1'b1;
         if (w) begin
            n.e_wr = 1'b1;  n.e_wdata = d;  n.mem[a] = d;  n.left = 2'd1;
         end else begin
            n.e_rdst = 1'b1;  n.left = 2'd2;
         end
      end
      return n;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) m <= model_reset(m);
      else        m <= model_step(m, req0, we0, addr0, wdata0, req1, we1, addr1, wdata1);
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         check("gnt",     {gnt0, gnt1},       {m.e_gnt0, m.e_gnt1});
         check("rvalid",  {rvalid0, rvalid1}, {m.e_rv0, m.e_rv1});
         check("rdata",   {rdata0, rdata1},   {m.e_rd0, m.e_rd1});
         check("ram_bus", {ram_write, ram_read, ram_addr, ram_wdata},
                          {m.e_wr, m.e_rdst, m.e_addr, m.e_wdata});
         check("status",  {busy, init_done},  {m.e_busy, m.e_done});
      end
   end

   // Counts in-order clear writes since the last reset.
   always @(negedge clk or negedge reset) begin
      if (!reset) init_writes <= 0;
      else if (ram_write && !init_done && ram_addr == init_writes[3:0] && ram_wdata == 8'd0)
         init_writes <= init_writes + 1;
   end

   function automatic logic sig_sel(input int s);
      case (s)
         0: return gnt0;
         1: return gnt1;
         2: return rvalid0;
         default: return rvalid1;
      endcase
   endfunction

   task automatic wait_on(input int s, input string nm, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!sig_sel(s) && cyc < 60);
      if (!sig_sel(s)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: no pulse after %0d cycles, expected one", nm, cyc);
      end
   endtask

   // Raise a request, hold it until its grant, then drop it (returns at negedge+1).
   task automatic issue(input logic p, input logic w, input logic [3:0] a,
                        input logic [7:0] d, output int cyc);
      if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
      else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
      wait_on(p ? 1 : 0, p ? "gnt1_wait" : "gnt0_wait", cyc);
      #1;
      if (p) req1 = 1'b0;
      else   req0 = 1'b0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, c2, n, rvc;
      int order [8];
      int exp_rr [4] = '{0, 1, 0, 1};

      reset = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = 4'd0; addr1 = 4'd0; wdata0 = 8'd0; wdata1 = 8'd0;
      repeat (3) @(negedge clk);
      check("rst_status", {busy, init_done, gnt0, gnt1, ram_write}, 5'b10000);
      #1;
      reset = 1'b1;

      // Port 1 requests during the clear: granted only once the clear is done.
      issue(1'b1, 1'b0, 4'd7, 8'd0, c);
      check("init_gnt_latency", c, 18);
      check("init_writes", init_writes, 16);
      check("init_done_at_gnt", init_done, 1);
      wait_on(3, "rvalid1_wait", c);
      check("rd_latency", c, 2);
      check("clear_readback", rdata1, 8'h00);
      #1;

      // Write from port 0, read it back from port 1.
      issue(1'b0, 1'b1, 4'd3, 8'hA5, c);
      check("wr_gnt_latency", c, 1);
      check("wr_bus", {ram_write, ram_read, ram_addr, ram_wdata}, {1'b1, 1'b0, 4'd3, 8'hA5});
      issue(1'b1, 1'b0, 4'd3, 8'd0, c);
      check("busy_wait_latency", c, 2);
      wait_on(3, "rvalid1_wait", c2);
      check("readback_a5", rdata1, 8'hA5);
      #1;
      issue(1'b0, 1'b1, 4'd5, 8'h11, c);
      issue(1'b1, 1'b1, 4'd9, 8'h3C, c);
      settle(1);

      // Both ports held: grants must alternate, starting with port 0.
      req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
      req1 = 1'b1; we1 = 1'b0; addr1 = 4'd9;
      n = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         @(negedge clk);
         if (gnt0 && n < 8) begin order[n] = 0; n++; end
         if (gnt1 && n < 8) begin order[n] = 1; n++; end
      end
      #1;
      req0 = 1'b0; req1 = 1'b0;
      check("rr_count", n, 4);
      for (int k = 0; k < 4; k++) check($sformatf("rr_grant_%0d", k), order[k], exp_rr[k]);
      settle(3);
      check("rr_rdata0", rdata0, 8'hA5);
      check("rr_rdata1", rdata1, 8'h3C);

      // Address change after capture must not affect the read in flight.
      issue(1'b0, 1'b0, 4'd5, 8'd0, c);
      check("capture_gnt_latency", c, 1);
      check("capture_addr", ram_addr, 4'd5);
      addr0 = 4'd9;
      wait_on(2, "rvalid0_wait", c);
      check("capture_rdata", rdata0, 8'h11);
      #1;

      // Single request wins even though port 0 was served last.
      issue(1'b0, 1'b1, 4'd0, 8'hFF, c);
      check("single_gnt_latency", c, 1);
      settle(1);

      // Reset during RDWAIT abandons the read.
      issue(1'b1, 1'b0, 4'd3, 8'd0, c);
      settle(1);
      check("rdwait_busy", busy, 1);
      reset = 1'b0;
      #1;
      check("rst_outputs",
            {gnt0, gnt1, rvalid0, rvalid1, ram_write, ram_read, ram_addr, ram_wdata,
             rdata0, rdata1, init_done, busy}, 36'h1);
      rvc = 0;
      repeat (3) begin
         @(negedge clk);
         if (rvalid0 || rvalid1) rvc++;
      end
      check("rst_no_rvalid", rvc, 0);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("restart_addr0", {ram_write, ram_addr, init_done}, {1'b1, 4'd0, 1'b0});
      #1;

      // First contest after reset goes to port 0, then port 1.
      req0 = 1'b1; we0 = 1'b1; addr0 = 4'd1; wdata0 = 8'h77;
      req1 = 1'b1; we1 = 1'b1; addr1 = 4'd2; wdata1 = 8'h88;
      n = 0;
      for (int i = 0; i < 60 && n < 2; i++) begin
         @(negedge clk);
         if (gnt0 && n < 8) begin order[n] = 0; n++; #1; req0 = 1'b0; end
         if (gnt1 && n < 8) begin order[n] = 1; n++; #1; req1 = 1'b0; end
      end
      #1;
      req0 = 1'b0; req1 = 1'b0;
      check("post_rst_count", n, 2);
      check("post_rst_first", order[0], 0);
      check("post_rst_second", order[1], 1);
      check("reinit_writes", init_writes, 16);
      settle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
